// File: rtl/mac8_if.sv
// rtl/mac8_if.sv - operand/result bundle for the 8-bit multiply-accumulate slice
interface mac8_if;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic [7:0] out;

    modport master (output a, output b, output c, input out);
    modport slave  (input a, input b, input c, output out);
endinterface

// File: rtl/mac8.sv
// rtl/mac8.sv - registered (a*b + c) mod 256 built from an explicit array multiplier
// Partial products reduced by a carry-save tree, c folded in before the final ripple adder.
module mac8 (
    input  logic   clk,
    input  logic   rst,
    mac8_if.slave  bus
);

    logic [7:0] pp [8];
    logic [7:0] s_a, c_a, s_b, c_b, s_c, c_c, s_d, c_d;
    logic [7:0] s_e, c_e, s_f, c_f, s_g, c_g;
    logic [7:0] sum;
    logic       carry;

    // Only columns 0..7 matter, so each shifted row is truncated to 8 bits.
    for (genvar i = 0; i < 8; i++) begin : g_pp
        assign pp[i] = bus.b[i] ? 8'(bus.a << i) : 8'h00;
    end

    function automatic logic [15:0] csa(input logic [7:0] x, input logic [7:0] y,
                                        input logic [7:0] z);
        logic [7:0] s;
        logic [7:0] cy;
        s  = x ^ y ^ z;
        cy = {(x[6:0] & y[6:0]) | (x[6:0] & z[6:0]) | (y[6:0] & z[6:0]), 1'b0};
        return {cy, s};
    endfunction

    always_comb begin
        {c_a, s_a} = csa(pp[0], pp[1], pp[2]);
        {c_b, s_b} = csa(pp[3], pp[4], pp[5]);
        {c_c, s_c} = csa(s_a, c_a, s_b);
        {c_d, s_d} = csa(c_b, pp[6], pp[7]);
        {c_e, s_e} = csa(s_c, c_c, s_d);
        {c_f, s_f} = csa(s_e, c_e, c_d);
        {c_g, s_g} = csa(s_f, c_f, bus.c);
    end

    // Carry out of bit 7 is discarded: the result wraps mod 256.
    always_comb begin
        sum   = 8'h00;
        carry = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sum[i] = s_g[i] ^ c_g[i] ^ carry;
            carry  = (s_g[i] & c_g[i]) | (carry & (s_g[i] ^ c_g[i]));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out <= 8'h00;
        end else begin
            bus.out <= sum;
        end
    end

endmodule

// File: tb/tb_mac8.sv
// tb/tb_mac8.sv - scoreboard bench for mac8 with directed and random vectors
module tb_mac8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    typedef struct {
        int         cyc;
        logic [7:0] val;
    } exp_t;

    exp_t q[$];

    mac8_if bus ();

    mac8 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic [7:0] ref_mac(input int a, input int b, input int c);
        return 8'((a * b + c) % 256);
    endfunction

    task automatic push(input int at, input logic [7:0] v);
        exp_t e;
        e.cyc = at;
        e.val = v;
        q.push_back(e);
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input logic [7:0] expv);
        @(posedge clk);
        #1;
        bus.a = a;
        bus.b = b;
        bus.c = c;
        push(cyc + 1, expv);
    endtask

    task automatic check_now(input string name, input logic [7:0] expv);
        total++;
        if (bus.out !== expv) begin
            bad++;
            $display("FAIL %s: out=%h expected=%h", name, bus.out, expv);
        end
    endtask

    task automatic reset_pulse(input int held);
        @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_now("reset_async_mid", 8'h00);
        push(cyc + 1, 8'h00);
        for (int k = 1; k < held; k++) begin
            @(posedge clk);
            #1;
            push(cyc + 1, 8'h00);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        push(cyc + 1, ref_mac(int'(bus.a), int'(bus.b), int'(bus.c)));
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            total++;
            bad++;
            $display("FAIL missed: no check for edge %0d expected=%h", e.cyc, e.val);
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            total++;
            if (bus.out !== e.val) begin
                bad++;
                $display("FAIL edge_%0d: out=%h expected=%h", cyc, bus.out, e.val);
            end
        end
    end

    logic [7:0] dir_a [9] = '{8'd3, 8'hFF, 8'hFF, 8'd16, 8'h80, 8'h00, 8'd1, 8'h0F, 8'h13};
    logic [7:0] dir_b [9] = '{8'd5, 8'hFF, 8'hFF, 8'd16, 8'd2,  8'hAA, 8'd1, 8'h00, 8'h11};
    logic [7:0] dir_c [9] = '{8'd7, 8'h00, 8'hFF, 8'd1,  8'h80, 8'hAB, 8'd1, 8'h33, 8'h00};
    logic [7:0] dir_e [9] = '{8'h16, 8'h01, 8'h00, 8'h01, 8'h80, 8'hAB, 8'h02, 8'h33, 8'h43};

    initial begin
        logic [7:0] ra, rb, rc;
        bus.a = 8'hFF;
        bus.b = 8'hFF;
        bus.c = 8'hFF;
        #1;
        check_now("reset_async_start", 8'h00);
        push(1, 8'h00);
        push(2, 8'h00);
        push(3, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        push(cyc + 1, 8'h00);

        for (int i = 0; i < 9; i++) begin
            drive(dir_a[i], dir_b[i], dir_c[i], dir_e[i]);
        end

        for (int i = 0; i < 10000; i++) begin
            if (i == 5000) begin
                reset_pulse(int'($urandom_range(1, 3)));
            end
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 8'($urandom);
            drive(ra, rb, rc, ref_mac(int'(ra), int'(rb), int'(rc)));
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: pending=%0d expected=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
